cpu_busmux: RTL
===============

CPU_BUSMUX -- requirements
Module: cpu_busmux

Interface
REQ-001 SHALL have parameter NUM_DEV, default 8, number of waitable device slots (1..8).
REQ-002 SHALL have parameter DEV_PAGE, default 8'hD0, address page of device slot 0; slot i occupies page DEV_PAGE+i.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, wait cycles before a bus error (2..65535).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- cpu_next_addr  in  16  next CPU address
- cpu_next_rd  in  1  next-cycle read
- cpu_next_we  in  1  next-cycle write
- cpu_di  out  8  read data to CPU
- cpu_enable  out  1  CPU advance; 0 = stall
- ram_we  out  1  RAM write strobe
- ram_data  in  8  RAM read data
- rom_data  in  8  ROM read data
- dev_data  in  8*NUM_DEV  slot i read data at bits [8i+7:8i]
- dev_ack  in  NUM_DEV  slot i access complete
- dev_stb  out  NUM_DEV  slot i strobe
- dev_wr  out  NUM_DEV  slot i write qualifier
- dev_rd  out  NUM_DEV  slot i read qualifier
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky timeout flag
- err_addr  out  16  address of the first timed-out access

Function
REQ-006 Decode SHALL be: addr[15]=0 RAM; addr[15:13]=3'b111 ROM; addr[15:8]=DEV_PAGE+i with i<NUM_DEV slot i; anything else unmapped.
REQ-007 ram_we SHALL be 1 only for RAM decode with cpu_next_we=1; combinational.
REQ-008 dev_stb[i] SHALL be 1 when slot i is decoded and (rd or we), FSM is IDLE or WAIT, and reset=0; dev_wr[i]=stb&we, dev_rd[i]=stb&rd&~we.
REQ-009 The registered select SHALL update on the clk edge only when cpu_enable=1; it holds during a stall.
REQ-010 cpu_di SHALL be muxed from the registered select: RAM read→ram_data, ROM→rom_data, slot i→dev_data slice i, unmapped or RAM write→8'h00, ERR→8'hFF.
REQ-011 cpu_enable SHALL be dev_ack[i] for a slot-i access in IDLE/WAIT, 1 in ERR, and 1 for RAM/ROM/unmapped/idle cycles.
REQ-012 FSM states SHALL be IDLE, WAIT, ERR; reset state IDLE.
REQ-013 IDLE→WAIT on a slot access with dev_ack[i]=0; WAIT→IDLE on dev_ack[i]=1; IDLE stays IDLE when ack is already 1 (zero-wait).
REQ-014 The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; at count TIMEOUT_CYC-1 with ack=0 the FSM SHALL go WAIT→ERR.
REQ-015 ERR SHALL last exactly one cycle, drop all dev_stb, release the CPU, and then go to IDLE.
REQ-016 On ERR entry bus_err SHALL set and err_addr SHALL latch cpu_next_addr only if bus_err was 0.
REQ-017 Ack and timeout on the same cycle: ack SHALL win (no error).
REQ-018 err_clr SHALL clear bus_err; a simultaneous set SHALL win.
REQ-019 An address change while in WAIT SHALL be ignored until completion, because the CPU is stalled.

Reset
REQ-020 Reset SHALL force: FSM IDLE, counter 0, select unmapped, bus_err 0, err_addr 16'h0000; and combinationally ram_we=0, dev_stb/wr/rd=0, cpu_enable=1, cpu_di=8'h00.
REQ-021 Reset mid-WAIT SHALL abort the access immediately without raising bus_err.

Configuration
REQ-022 Macro BUSMUX_TIMEOUT_EN: when defined, REQ-014..018 apply; when undefined, there is no counter, WAIT persists until ack, ERR is unreachable, bus_err=0, err_addr=0, and err_clr is ignored.

Structure
REQ-023 Package busmux_pkg SHALL hold the address-map constants (RAM/ROM decode, DEV_PAGE default), the select encoding, and the FSM state typedef.
REQ-024 Sub-module busmux_decode SHALL hold the combinational address decode (REQ-006), producing a one-hot slot vector plus RAM/ROM/unmapped flags.

Verification
REQ-025 RAM write 0x1234, we=1 → ram_we=1 same cycle, no dev_stb, cpu_enable=1.
REQ-026 ROM read 0xE010 with rom_data=0xA5 → cpu_di=0xA5 the cycle after the address.
REQ-027 Read 0xD300 (slot 3), ack delayed 4 cycles, dev_data[31:24]=0x5C → cpu_enable=0 for 4 cycles, dev_rd[3]=1 throughout, cpu_di=0x5C after ack.
REQ-028 TIMEOUT_CYC=16, write 0xD500 with no ack → ERR on cycle 16, cpu_di=0xFF, bus_err=1, err_addr=0xD500; second timeout leaves err_addr unchanged; err_clr → bus_err=0.
REQ-029 Reset asserted in cycle 3 of a slot-6 wait → dev_stb=0 and cpu_enable=1 immediately, FSM IDLE, bus_err=0.
REQ-030 NUM_DEV=4, read 0xD600 → unmapped, cpu_di=0x00, no strobes, no stall.

Source files
------------

// File: rtl/busmux_pkg.sv
// Shared address map, read-select encoding and FSM state type for the CPU bus multiplexer.
package busmux_pkg;

  localparam logic       RAM_A15          = 1'b0;
  localparam logic [2:0] ROM_TOP3         = 3'b111;
  localparam logic [7:0] DEV_PAGE_DEFAULT = 8'hD0;
  localparam int         MAX_DEV          = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_ROM,
    SEL_DEV,
    SEL_ERR
  } sel_kind_t;

  typedef struct packed {
    sel_kind_t  kind;
    logic [2:0] slot;
  } sel_t;

  localparam sel_t SEL_RESET = '{kind: SEL_NONE, slot: 3'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_DEV-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_DEV; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/busmux_decode.sv
// Combinational address decode: RAM, ROM, one-hot device slot, or unmapped.
module busmux_decode
  import busmux_pkg::*;
#(
  parameter int         NUM_DEV  = 8,
  parameter logic [7:0] DEV_PAGE = DEV_PAGE_DEFAULT
) (
  input  logic [15:0]        addr,
  output logic               is_ram,
  output logic               is_rom,
  output logic               is_unmapped,
  output logic [NUM_DEV-1:0] slot_hit
);

  // NOTE: every output gets a default at the top of the block so no path leaves one unassigned (no latch).
  always_comb begin
    is_ram   = (addr[15] == RAM_A15);
    is_rom   = (addr[15:13] == ROM_TOP3);
    slot_hit = '0;
    for (int i = 0; i < NUM_DEV; i++)
      slot_hit[i] = !is_ram && !is_rom && (addr[15:8] == DEV_PAGE + 8'(i));
    is_unmapped = !is_ram && !is_rom && !(|slot_hit);
  end

endmodule

// File: rtl/cpu_busmux.sv
// CPU bus multiplexer: decodes the next-cycle address, stalls on slow devices, muxes read data.
// Optional wait timeout with sticky bus error is enabled by defining BUSMUX_TIMEOUT_EN.
module cpu_busmux
  import busmux_pkg::*;
#(
  parameter int         NUM_DEV     = 8,
  parameter logic [7:0] DEV_PAGE    = DEV_PAGE_DEFAULT,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          cpu_next_addr,
  input  logic                 cpu_next_rd,
  input  logic                 cpu_next_we,
  output logic [7:0]           cpu_di,
  output logic                 cpu_enable,
  output logic                 ram_we,
  input  logic [7:0]           ram_data,
  input  logic [7:0]           rom_data,
  input  logic [8*NUM_DEV-1:0] dev_data,
  input  logic [NUM_DEV-1:0]   dev_ack,
  output logic [NUM_DEV-1:0]   dev_stb,
  output logic [NUM_DEV-1:0]   dev_wr,
  output logic [NUM_DEV-1:0]   dev_rd,
  input  logic                 err_clr,
  output logic                 bus_err,
  output logic [15:0]          err_addr
);

  logic               is_ram, is_rom, is_unmapped;
  logic [NUM_DEV-1:0] slot_hit;
  logic [MAX_DEV-1:0] slot_hit_pad;
  logic [2:0]         slot_idx;
  logic               access, dev_access, dev_acked;
  state_t             state_q, state_d;
  sel_t               sel_q, sel_d;

  busmux_decode #(.NUM_DEV(NUM_DEV), .DEV_PAGE(DEV_PAGE)) u_decode (
    .addr        (cpu_next_addr),
    .is_ram      (is_ram),
    .is_rom      (is_rom),
    .is_unmapped (is_unmapped),
    .slot_hit    (slot_hit)
  );

  assign access     = cpu_next_rd | cpu_next_we;
  assign dev_access = access & (|slot_hit);
  assign dev_acked  = |(slot_hit & dev_ack);

  always_comb begin
    slot_hit_pad                = '0;
    slot_hit_pad[NUM_DEV-1:0]   = slot_hit;
    slot_idx                    = onehot_to_idx(slot_hit_pad);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

`ifdef BUSMUX_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout;
  logic        err_set;

  assign timeout = (state_q == ST_WAIT) && (wait_cnt == 16'(TIMEOUT_CYC - 1));

  // Counter is zero whenever not waiting, so it is already clear on entry to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_cnt <= '0;
    else if (state_q != ST_WAIT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 16'd1;
  end

  assign err_set = (state_q == ST_WAIT) && (state_d == ST_ERR);

  // A new timeout beats a simultaneous clear; the address of the first one is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err  <= 1'b0;
      err_addr <= 16'h0000;
    end else if (err_set) begin
      bus_err <= 1'b1;
      if (!bus_err) err_addr <= cpu_next_addr;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end
`else
  logic     unused_err_clr;
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign unused_err_clr = err_clr;
  assign bus_err        = 1'b0;
  assign err_addr       = 16'h0000;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (dev_access && !dev_acked) state_d = ST_WAIT;
      ST_WAIT: begin
        // Ack is tested first so a same-cycle ack beats the timeout.
        if (!dev_access || dev_acked) state_d = ST_IDLE;
`ifdef BUSMUX_TIMEOUT_EN
        else if (timeout)             state_d = ST_ERR;
`endif
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_we     = 1'b0;
    dev_stb    = '0;
    dev_wr     = '0;
    dev_rd     = '0;
    cpu_enable = 1'b1;
    if (!reset) begin
      ram_we = is_ram & cpu_next_we;
      if (state_q != ST_ERR && access) begin
        dev_stb = slot_hit;
        dev_wr  = cpu_next_we ? slot_hit : '0;
        dev_rd  = (cpu_next_rd && !cpu_next_we) ? slot_hit : '0;
        if (dev_access) cpu_enable = dev_acked;
      end
    end
  end

  always_comb begin
    sel_d = SEL_RESET;
    if (state_q == ST_ERR) begin
      sel_d.kind = SEL_ERR;
    end else if (access) begin
      if (is_ram)             sel_d.kind = cpu_next_we ? SEL_NONE : SEL_RAM;
      else if (is_rom)        sel_d.kind = SEL_ROM;
      else if (!is_unmapped) begin
        sel_d.kind = SEL_DEV;
        sel_d.slot = slot_idx;
      end
    end
  end

  // The select names the access that completed, so it only moves when the CPU advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sel_q <= SEL_RESET;
    else if (cpu_enable) sel_q <= sel_d;
  end

  always_comb begin
    cpu_di = 8'h00;
    if (!reset) begin
      case (sel_q.kind)
        SEL_RAM: cpu_di = ram_data;
        SEL_ROM: cpu_di = rom_data;
        SEL_DEV: begin
          for (int i = 0; i < NUM_DEV; i++)
            if (sel_q.slot == 3'(i)) cpu_di = dev_data[8*i +: 8];
        end
        SEL_ERR: cpu_di = 8'hFF;
        default: cpu_di = 8'h00;
      endcase
    end
  end

endmodule
